// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer.
// Drives the next PC, issues IMEM reads and presents one slot to decode.
module fetch_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [63:0] INST_ADDR,
  output logic [63:0] NEXT_ADDR,
  input  logic        BR_TAKEN,
  input  logic [63:0] BR_TARGET,
  input  logic        STALL,
  output logic        IMEM_REQ,
  output logic [63:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic        IF_VALID,
  output logic [31:0] IF_INST,
  output logic [63:0] IF_PC,
  output logic [31:0] FETCH_CNT,
  output logic        MISALIGN,
  output logic        TIMEOUT_ERR
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        misalign_q, misalign_d;
  logic        timeout_err_q, timeout_err_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [63:0] drain_addr_q, drain_addr_d;

  logic        req;
  logic [63:0] br_addr;

  assign req     = (state_q == FETCH) || (state_q == DRAIN);
  assign br_addr = {BR_TARGET[63:2], 2'b00};

  // FSM transitions, slot capture/consume and delivered-count update
  always_comb begin
    state_d      = state_q;
    if_valid_d   = if_valid_q;
    if_inst_d    = if_inst_q;
    if_pc_d      = if_pc_q;
    fetch_cnt_d  = fetch_cnt_q;
    drain_addr_d = drain_addr_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (BR_TAKEN) begin
          if (IMEM_ACK) begin
            state_d = FETCH;
          end else begin
            state_d      = DRAIN;
            drain_addr_d = INST_ADDR;
          end
        end else if (IMEM_ACK) begin
          state_d    = HOLD;
          if_valid_d = 1'b1;
          if_inst_d  = IMEM_RDATA;
          if_pc_d    = INST_ADDR;
        end
      end
      HOLD: begin
        if (BR_TAKEN) begin
          state_d    = FETCH;
          if_valid_d = 1'b0;
        end else if (!STALL) begin
          state_d    = FETCH;
          if_valid_d = 1'b0;
          if (fetch_cnt_q != 32'hFFFF_FFFF) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
          end
        end
      end
      DRAIN: begin
        if (IMEM_ACK) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky misalign flag and request wait counter with timeout flag
  always_comb begin
    misalign_d    = misalign_q;
    timeout_err_d = timeout_err_q;
    wait_cnt_d    = 16'd0;
    if (BR_TAKEN && (BR_TARGET[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
    if (req && !IMEM_ACK) begin
      if (wait_cnt_q != 16'hFFFF) begin
        wait_cnt_d = wait_cnt_q + 16'd1;
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
      if (wait_cnt_d >= TMO) begin
        timeout_err_d = 1'b1;
      end
    end
  end

  // Next-PC select: redirect beats sequential advance beats hold
  always_comb begin
    NEXT_ADDR = INST_ADDR;
    if (RST_N) begin
      if (BR_TAKEN) begin
        NEXT_ADDR = br_addr;
      end else if ((state_q == FETCH) && IMEM_ACK) begin
        NEXT_ADDR = INST_ADDR + 64'd4;
      end
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      if_valid_q    <= 1'b0;
      if_inst_q     <= 32'd0;
      if_pc_q       <= 64'd0;
      fetch_cnt_q   <= 32'd0;
      misalign_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= 16'd0;
      drain_addr_q  <= 64'd0;
    end else begin
      state_q       <= state_d;
      if_valid_q    <= if_valid_d;
      if_inst_q     <= if_inst_d;
      if_pc_q       <= if_pc_d;
      fetch_cnt_q   <= fetch_cnt_d;
      misalign_q    <= misalign_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
      drain_addr_q  <= drain_addr_d;
    end
  end

  assign IMEM_REQ    = req;
  assign IMEM_ADDR   = (state_q == FETCH) ? INST_ADDR :
                       (state_q == DRAIN) ? drain_addr_q : 64'd0;
  assign IF_VALID    = if_valid_q;
  assign IF_INST     = if_inst_q;
  assign IF_PC       = if_pc_q;
  assign FETCH_CNT   = fetch_cnt_q;
  assign MISALIGN    = misalign_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios for fetch_ctrl.
// Holds an external PC register fed from NEXT_ADDR.
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [63:0] INST_ADDR;
  logic [63:0] NEXT_ADDR;
  logic        BR_TAKEN;
  logic [63:0] BR_TARGET;
  logic        STALL;
  logic        IMEM_REQ;
  logic [63:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic        IF_VALID;
  logic [31:0] IF_INST;
  logic [63:0] IF_PC;
  logic [31:0] FETCH_CNT;
  logic        MISALIGN;
  logic        TIMEOUT_ERR;

  int n_checks = 0;
  int n_fail = 0;

  fetch_ctrl #(.TIMEOUT(255)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .INST_ADDR(INST_ADDR), .NEXT_ADDR(NEXT_ADDR),
    .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
    .STALL(STALL),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .IF_VALID(IF_VALID), .IF_INST(IF_INST), .IF_PC(IF_PC),
    .FETCH_CNT(FETCH_CNT),
    .MISALIGN(MISALIGN), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) INST_ADDR <= 64'd0;
    else        INST_ADDR <= NEXT_ADDR;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    BR_TAKEN = 1'b0; BR_TARGET = 64'd0; STALL = 1'b0;
    IMEM_ACK = 1'b0; IMEM_RDATA = 32'd0;
    cyc(); cyc();
    RST_N = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    BR_TAKEN = 1'b1; BR_TARGET = 64'h100; STALL = 1'b0;
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (NEXT_ADDR !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_next_addr act=%h exp=0", NEXT_ADDR);
    end
    cyc(); cyc();
    n_checks++;
    if ({IMEM_REQ, IF_VALID, MISALIGN, TIMEOUT_ERR} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_flags act=%b exp=0000",
               {IMEM_REQ, IF_VALID, MISALIGN, TIMEOUT_ERR});
    end
    n_checks++;
    if ({IF_INST, IF_PC, FETCH_CNT, IMEM_ADDR} !== '0) begin
      n_fail++;
      $display("FAIL rst_data inst=%h pc=%h cnt=%0d addr=%h exp=0",
               IF_INST, IF_PC, FETCH_CNT, IMEM_ADDR);
    end
    BR_TAKEN = 1'b0; IMEM_ACK = 1'b0;
    RST_N = 1'b1;
    #1;
    n_checks++;
    if (IMEM_REQ !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_req act=%b exp=0", IMEM_REQ);
    end
    cyc();
    n_checks++;
    if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'd0) begin
      n_fail++;
      $display("FAIL first_fetch req=%b addr=%h exp=1/0", IMEM_REQ, IMEM_ADDR);
    end
  endtask

  task automatic test_basic_stream();
    do_reset();
    cyc();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'(i * 4)) begin
        n_fail++;
        $display("FAIL stream_req%0d req=%b addr=%h exp=1/%h",
                 i, IMEM_REQ, IMEM_ADDR, 64'(i * 4));
      end
      IMEM_ACK = 1'b1; IMEM_RDATA = 32'h1000 + 32'(i);
      cyc();
      IMEM_ACK = 1'b0;
      n_checks++;
      if (IF_VALID !== 1'b1 || IF_PC !== 64'(i * 4) ||
          IF_INST !== 32'h1000 + 32'(i) || IMEM_REQ !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_slot%0d v=%b pc=%h inst=%h req=%b",
                 i, IF_VALID, IF_PC, IF_INST, IMEM_REQ);
      end
      cyc();
      n_checks++;
      if (IF_VALID !== 1'b0 || FETCH_CNT !== 32'(i + 1)) begin
        n_fail++;
        $display("FAIL stream_cnt%0d v=%b cnt=%0d exp=0/%0d",
                 i, IF_VALID, FETCH_CNT, i + 1);
      end
    end
  endtask

  task automatic test_ack_delay();
    do_reset();
    cyc();
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'd0 || INST_ADDR !== 64'd0) begin
        n_fail++;
        $display("FAIL delay_wait%0d req=%b addr=%h pc=%h exp=1/0/0",
                 i, IMEM_REQ, IMEM_ADDR, INST_ADDR);
      end
      if (i < 5) cyc();
    end
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h55;
    cyc();
    IMEM_ACK = 1'b0;
    n_checks++;
    if (INST_ADDR !== 64'h4 || IF_VALID !== 1'b1 || IF_INST !== 32'h55) begin
      n_fail++;
      $display("FAIL delay_done pc=%h v=%b inst=%h exp=4/1/55",
               INST_ADDR, IF_VALID, IF_INST);
    end
  endtask

  task automatic test_stall_branch();
    do_reset();
    cyc();
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hAA;
    cyc();
    IMEM_ACK = 1'b0; STALL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (IF_VALID !== 1'b1 || IF_PC !== 64'd0 || IF_INST !== 32'hAA ||
          IMEM_REQ !== 1'b0 || INST_ADDR !== 64'h4) begin
        n_fail++;
        $display("FAIL stall_hold%0d v=%b pc=%h inst=%h req=%b ia=%h",
                 i, IF_VALID, IF_PC, IF_INST, IMEM_REQ, INST_ADDR);
      end
      cyc();
    end
    BR_TAKEN = 1'b1; BR_TARGET = 64'h100;
    #1;
    n_checks++;
    if (NEXT_ADDR !== 64'h100) begin
      n_fail++;
      $display("FAIL stall_br_next act=%h exp=100", NEXT_ADDR);
    end
    cyc();
    BR_TAKEN = 1'b0; STALL = 1'b0;
    #1;
    n_checks++;
    if (IF_VALID !== 1'b0 || FETCH_CNT !== 32'd0 ||
        IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h100) begin
      n_fail++;
      $display("FAIL stall_flush v=%b cnt=%0d req=%b addr=%h exp=0/0/1/100",
               IF_VALID, FETCH_CNT, IMEM_REQ, IMEM_ADDR);
    end
  endtask

  task automatic test_drain();
    do_reset();
    cyc();
    for (int i = 0; i < 2; i++) begin
      IMEM_ACK = 1'b1;
      cyc();
      IMEM_ACK = 1'b0;
      cyc();
    end
    n_checks++;
    if (IMEM_ADDR !== 64'h8 || IMEM_REQ !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_pre addr=%h req=%b exp=8/1", IMEM_ADDR, IMEM_REQ);
    end
    BR_TAKEN = 1'b1; BR_TARGET = 64'h200;
    cyc();
    BR_TAKEN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h8 ||
          INST_ADDR !== 64'h200 || IF_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_wait%0d req=%b addr=%h pc=%h v=%b",
                 i, IMEM_REQ, IMEM_ADDR, INST_ADDR, IF_VALID);
      end
      cyc();
    end
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hDEAD;
    #1;
    n_checks++;
    if (NEXT_ADDR !== 64'h200) begin
      n_fail++;
      $display("FAIL drain_ack_next act=%h exp=200", NEXT_ADDR);
    end
    cyc();
    IMEM_ACK = 1'b0;
    #1;
    n_checks++;
    if (IF_VALID !== 1'b0 || IMEM_ADDR !== 64'h200 ||
        IMEM_REQ !== 1'b1 || FETCH_CNT !== 32'd2) begin
      n_fail++;
      $display("FAIL drain_done v=%b addr=%h req=%b cnt=%0d exp=0/200/1/2",
               IF_VALID, IMEM_ADDR, IMEM_REQ, FETCH_CNT);
    end
  endtask

  task automatic test_misalign_timeout();
    do_reset();
    cyc();
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hBAD;
    BR_TAKEN = 1'b1; BR_TARGET = 64'h103;
    #1;
    n_checks++;
    if (NEXT_ADDR !== 64'h100) begin
      n_fail++;
      $display("FAIL mis_next act=%h exp=100", NEXT_ADDR);
    end
    cyc();
    IMEM_ACK = 1'b0; BR_TAKEN = 1'b0;
    #1;
    n_checks++;
    if (MISALIGN !== 1'b1 || IF_VALID !== 1'b0 ||
        IMEM_ADDR !== 64'h100 || FETCH_CNT !== 32'd0) begin
      n_fail++;
      $display("FAIL mis_flag m=%b v=%b addr=%h cnt=%0d exp=1/0/100/0",
               MISALIGN, IF_VALID, IMEM_ADDR, FETCH_CNT);
    end
    repeat (254) cyc();
    n_checks++;
    if (TIMEOUT_ERR !== 1'b0 || IMEM_REQ !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_early err=%b req=%b exp=0/1", TIMEOUT_ERR, IMEM_REQ);
    end
    cyc();
    n_checks++;
    if (TIMEOUT_ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_set act=%b exp=1", TIMEOUT_ERR);
    end
    cyc();
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h77;
    cyc();
    IMEM_ACK = 1'b0;
    cyc();
    n_checks++;
    if (TIMEOUT_ERR !== 1'b1 || MISALIGN !== 1'b1 || FETCH_CNT !== 32'd1) begin
      n_fail++;
      $display("FAIL sticky err=%b m=%b cnt=%0d exp=1/1/1",
               TIMEOUT_ERR, MISALIGN, FETCH_CNT);
    end
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (TIMEOUT_ERR !== 1'b0 || MISALIGN !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clr err=%b m=%b exp=0/0", TIMEOUT_ERR, MISALIGN);
    end
  endtask

  task automatic test_reset_drain();
    do_reset();
    cyc();
    IMEM_ACK = 1'b1;
    cyc();
    IMEM_ACK = 1'b0;
    cyc();
    BR_TAKEN = 1'b1; BR_TARGET = 64'h40;
    cyc();
    BR_TAKEN = 1'b1; BR_TARGET = 64'h80;
    cyc();
    BR_TAKEN = 1'b0;
    #1;
    n_checks++;
    if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h4 || INST_ADDR !== 64'h80) begin
      n_fail++;
      $display("FAIL redrain req=%b addr=%h pc=%h exp=1/4/80",
               IMEM_REQ, IMEM_ADDR, INST_ADDR);
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (IMEM_REQ !== 1'b0 || IMEM_ADDR !== 64'd0 || IF_VALID !== 1'b0 ||
        FETCH_CNT !== 32'd0 || INST_ADDR !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_drain req=%b addr=%h v=%b cnt=%0d pc=%h",
               IMEM_REQ, IMEM_ADDR, IF_VALID, FETCH_CNT, INST_ADDR);
    end
    cyc();
    RST_N = 1'b1;
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hCAFE;
    #1;
    n_checks++;
    if (IMEM_REQ !== 1'b0 || NEXT_ADDR !== 64'd0) begin
      n_fail++;
      $display("FAIL late_ack req=%b next=%h exp=0/0", IMEM_REQ, NEXT_ADDR);
    end
    cyc();
    IMEM_ACK = 1'b0;
    #1;
    n_checks++;
    if (IF_VALID !== 1'b0 || INST_ADDR !== 64'd0 ||
        IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'd0) begin
      n_fail++;
      $display("FAIL restart v=%b pc=%h req=%b addr=%h exp=0/0/1/0",
               IF_VALID, INST_ADDR, IMEM_REQ, IMEM_ADDR);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_ack_delay();
    test_stall_branch();
    test_drain();
    test_misalign_timeout();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
